// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared defaults and forward-select encodings for the hazard unit
package mycpu_pkg;

  localparam int NREG_DEF = 32;
  localparam int RAW_DEF  = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // M beats W: M holds the younger value of the register
  function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_M;
    else if (hit_w) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register-busy scoreboard for long-latency writers
module hazard_scoreboard
  import mycpu_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int RAW  = RAW_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            set_en,
  input  logic [RAW-1:0]  set_reg,
  input  logic            clr_en,
  input  logic [RAW-1:0]  clr_reg,
  input  logic [RAW-1:0]  rd_a,
  input  logic [RAW-1:0]  rd_b,
  output logic [NREG-1:0] busy,
  output logic            busy_a,
  output logic            busy_b
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next busy vector: clear first so a same-cycle set of that register wins; r0 never busy
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_reg] = 1'b0;
    if (set_en) busy_d[set_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy register array, cleared asynchronously on reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy   = busy_q;
  assign busy_a = busy_q[rd_a];
  assign busy_b = busy_q[rd_b];

endmodule

// File: rtl/hazard_sb.sv
// rtl/hazard_sb.sv - MIPS 5-stage hazard unit with long-op scoreboard; HAZARD_PERF_EN adds stall counters
module hazard_sb
  import mycpu_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int RAW   = RAW_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_stall,
  input  logic             d_stall,
  input  logic [RAW-1:0]   rsD,
  input  logic [RAW-1:0]   rtD,
  input  logic [RAW-1:0]   rsE,
  input  logic [RAW-1:0]   rtE,
  input  logic             branchD,
  input  logic             regjumpD,
  input  logic [RAW-1:0]   writeregE,
  input  logic [RAW-1:0]   writeregM,
  input  logic [RAW-1:0]   writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             div_stallE,
  input  logic             flush_exceptionM,
  input  logic             longopM,
  input  logic             lo_done,
  input  logic [RAW-1:0]   lo_reg,
  output logic             forwardaD,
  output logic             forwardbD,
  output logic [1:0]       forwardaE,
  output logic [1:0]       forwardbE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             stallW,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_sb_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
`endif
  output logic [NREG-1:0]  sb_busy
);

  logic fwd_m_ok;
  logic fwd_w_ok;
  logic lwstall;
  logic branchstall;
  logic jumpstall;
  logic sbstall;
  logic sb_set;
  logic busy_rs;
  logic busy_rt;
  logic longop_hit;

  // A long op in M is not forwardable; its result arrives later through lo_done
  assign fwd_m_ok = regwriteM & ~longopM;
  assign fwd_w_ok = regwriteW;

  // Forward-select generation for D and E sources
  always_comb begin
    forwardaE = fwd_sel(fwd_m_ok & (rsE != '0) & (rsE == writeregM),
                        fwd_w_ok & (rsE != '0) & (rsE == writeregW));
    forwardbE = fwd_sel(fwd_m_ok & (rtE != '0) & (rtE == writeregM),
                        fwd_w_ok & (rtE != '0) & (rtE == writeregW));
    forwardaD = fwd_m_ok & (rsD != '0) & (rsD == writeregM);
    forwardbD = fwd_m_ok & (rtD != '0) & (rtD == writeregM);
  end

  // A long op only enters the scoreboard once it actually leaves M
  assign sb_set = longopM & regwriteM & ~stallM & ~flush_exceptionM & (writeregM != '0);

  hazard_scoreboard #(
    .NREG (NREG),
    .RAW  (RAW)
  ) u_sb (
    .clk     (clk),
    .resetn  (resetn),
    .set_en  (sb_set),
    .set_reg (writeregM),
    .clr_en  (lo_done),
    .clr_reg (lo_reg),
    .rd_a    (rsD),
    .rd_b    (rtD),
    .busy    (sb_busy),
    .busy_a  (busy_rs),
    .busy_b  (busy_rt)
  );

  // Hazard terms; a long op still sitting in M is covered before it reaches the scoreboard
  always_comb begin
    longop_hit  = longopM & regwriteM & (writeregM != '0) &
                  ((writeregM == rsD) | (writeregM == rtD));
    lwstall     = memtoregE & ((rtE == rsD) | (rtE == rtD));
    branchstall = branchD & ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
                             (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));
    jumpstall   = regjumpD & ((regwriteE & (writeregE == rsD)) |
                              (memtoregM & (writeregM == rsD)));
    sbstall     = busy_rs | busy_rt | longop_hit;
  end

  // Stall chain from the back of the pipe forward, plus flushes
  always_comb begin
    stallW = i_stall | d_stall;
    stallM = stallW;
    stallE = stallM | div_stallE;
    stallD = stallE | lwstall | branchstall | jumpstall | sbstall;
    stallF = stallD & ~flush_exceptionM;
    flushD = flush_exceptionM;
    flushM = flush_exceptionM;
    flushW = flush_exceptionM;
    flushE = flush_exceptionM | (stallD & ~stallE);
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] sb_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
      sb_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stallD && (stall_cnt_q != '1))           stall_cnt_q <= stall_cnt_q + 1'b1;
      if (sbstall && (sb_cnt_q != '1))             sb_cnt_q    <= sb_cnt_q + 1'b1;
      if (flush_exceptionM && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_sb_cnt    = sb_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// tb/tb_hazard_sb.sv - table-driven and sequence checks for hazard_sb
module tb_hazard_sb;

  logic       clk;
  logic       resetn;
  logic       i_stall, d_stall;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic       branchD, regjumpD;
  logic [4:0] writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW;
  logic       memtoregE, memtoregM;
  logic       div_stallE, flush_exceptionM, longopM, lo_done;
  logic [4:0] lo_reg;
  logic       forwardaD, forwardbD;
  logic [1:0] forwardaE, forwardbE;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushD, flushE, flushM, flushW;
  logic [31:0] sb_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_sb_cnt, perf_flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  hazard_sb dut (
    .clk(clk), .resetn(resetn), .i_stall(i_stall), .d_stall(d_stall),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .branchD(branchD), .regjumpD(regjumpD),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .div_stallE(div_stallE),
    .flush_exceptionM(flush_exceptionM), .longopM(longopM),
    .lo_done(lo_done), .lo_reg(lo_reg),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_sb_cnt(perf_sb_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .sb_busy(sb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {fwdaD, fwdbD, fwdaE[1:0], fwdbE[1:0], stallF,D,E,M,W, flushD,E,M,W}
  logic [14:0] obus;
  assign obus = {forwardaD, forwardbD, forwardaE, forwardbE,
                 stallF, stallD, stallE, stallM, stallW,
                 flushD, flushE, flushM, flushW};

  typedef struct {
    logic       is, ds;
    logic [4:0] rsD, rtD, rsE, rtE;
    logic       br, rj;
    logic [4:0] wE, wM, wW;
    logic       rwE, rwM, rwW, mE, mM, dv, fx, lop;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[$];
  vec_t cv;

  function automatic logic [14:0] ex(input logic fad, input logic fbd, input logic [1:0] fae,
                                     input logic [1:0] fbe, input logic [4:0] st, input logic [3:0] fl);
    return {fad, fbd, fae, fbe, st, fl};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic zero_in();
    i_stall = 0; d_stall = 0; rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    branchD = 0; regjumpD = 0; writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0; memtoregE = 0; memtoregM = 0;
    div_stallE = 0; flush_exceptionM = 0; longopM = 0; lo_done = 0; lo_reg = 0;
  endtask

  task automatic apply(input vec_t v);
    i_stall = v.is; d_stall = v.ds; rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
    branchD = v.br; regjumpD = v.rj; writeregE = v.wE; writeregM = v.wM; writeregW = v.wW;
    regwriteE = v.rwE; regwriteM = v.rwM; regwriteW = v.rwW; memtoregE = v.mE;
    memtoregM = v.mM; div_stallE = v.dv; flush_exceptionM = v.fx; longopM = v.lop;
    lo_done = 0; lo_reg = 0;
  endtask

  task automatic clr();
    cv = '{default: 0};
  endtask

  task automatic do_reset();
    @(negedge clk);
    zero_in();
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    zero_in();
    resetn = 1'b0;

    // Combinational vectors, busy assumed clear for the registers involved
    clr(); cv.exp = ex(0,0,2'b00,2'b00,5'b00000,4'b0000); tbl.push_back(cv);
    clr(); cv.rsE = 5; cv.wM = 5; cv.rwM = 1; cv.wW = 5; cv.rwW = 1;
           cv.exp = ex(0,0,2'b10,2'b00,5'b00000,4'b0000); tbl.push_back(cv);
    clr(); cv.rsE = 5; cv.wM = 5; cv.rwM = 0; cv.wW = 5; cv.rwW = 1;
           cv.exp = ex(0,0,2'b01,2'b00,5'b00000,4'b0000); tbl.push_back(cv);
    clr(); cv.rtE = 7; cv.wM = 7; cv.rwM = 1; cv.lop = 1; cv.wW = 7; cv.rwW = 1;
           cv.exp = ex(0,0,2'b00,2'b01,5'b00000,4'b0000); tbl.push_back(cv);
    clr(); cv.rwM = 1; cv.rwW = 1;
           cv.exp = ex(0,0,2'b00,2'b00,5'b00000,4'b0000); tbl.push_back(cv);
    clr(); cv.rsD = 4; cv.rtD = 6; cv.wM = 6; cv.rwM = 1;
           cv.exp = ex(0,1,2'b00,2'b00,5'b00000,4'b0000); tbl.push_back(cv);
    clr(); cv.mE = 1; cv.rtE = 8; cv.rsD = 8; cv.rtD = 2;
           cv.exp = ex(0,0,2'b00,2'b00,5'b11000,4'b0100); tbl.push_back(cv);
    clr(); cv.br = 1; cv.rsD = 3; cv.rtD = 4; cv.rwE = 1; cv.wE = 4;
           cv.exp = ex(0,0,2'b00,2'b00,5'b11000,4'b0100); tbl.push_back(cv);
    clr(); cv.br = 1; cv.rsD = 3; cv.rtD = 4; cv.mM = 1; cv.wM = 3; cv.rwM = 1;
           cv.exp = ex(1,0,2'b00,2'b00,5'b11000,4'b0100); tbl.push_back(cv);
    clr(); cv.rj = 1; cv.rsD = 10; cv.rtD = 11; cv.rwE = 1; cv.wE = 11;
           cv.exp = ex(0,0,2'b00,2'b00,5'b00000,4'b0000); tbl.push_back(cv);
    clr(); cv.rj = 1; cv.rsD = 10; cv.rtD = 11; cv.rwE = 1; cv.wE = 10;
           cv.exp = ex(0,0,2'b00,2'b00,5'b11000,4'b0100); tbl.push_back(cv);
    clr(); cv.lop = 1; cv.rwM = 1; cv.wM = 12; cv.rtD = 12; cv.rsD = 1;
           cv.exp = ex(0,0,2'b00,2'b00,5'b11000,4'b0100); tbl.push_back(cv);
    clr(); cv.is = 1;
           cv.exp = ex(0,0,2'b00,2'b00,5'b11111,4'b0000); tbl.push_back(cv);
    clr(); cv.dv = 1;
           cv.exp = ex(0,0,2'b00,2'b00,5'b11100,4'b0000); tbl.push_back(cv);
    clr(); cv.fx = 1; cv.mE = 1; cv.rtE = 8; cv.rsD = 8;
           cv.exp = ex(0,0,2'b00,2'b00,5'b01000,4'b1111); tbl.push_back(cv);
    clr(); cv.fx = 1; cv.ds = 1;
           cv.exp = ex(0,0,2'b00,2'b00,5'b01111,4'b1111); tbl.push_back(cv);

    // Reset state
    @(negedge clk);
    chk("reset_busy", sb_busy, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1 chk("reset_outputs", obus, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1 chk($sformatf("vec%0d", i), obus, tbl[i].exp);
    end

    // Vectors 3 and 11 committed long ops to r7 and r12
    @(negedge clk);
    zero_in();
    #1 chk("busy_after_table", sb_busy, (32'd1 << 7) | (32'd1 << 12));
    // Asynchronous reset mid-cycle clears pending entries at once
    #2 resetn = 1'b0;
    #1 chk("async_reset_busy", sb_busy, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Long op to r9: set after the edge, stall held until lo_done
    @(negedge clk);
    longopM = 1; regwriteM = 1; writeregM = 9;
    #1 chk("busy9_before_edge", sb_busy, 0);
    @(negedge clk);
    zero_in(); rsD = 9;
    #1 chk("busy9_set", sb_busy, 32'd1 << 9);
    chk("busy9_stallD", stallD, 1);
    @(negedge clk);
    chk("busy9_stall_hold", stallD, 1);
    lo_done = 1; lo_reg = 9;
    #1 chk("busy9_stall_pre_clear", stallD, 1);
    @(negedge clk);
    lo_done = 0;
    #1 chk("busy9_cleared", sb_busy, 0);
    chk("busy9_release", stallD, 0);

    // Same-cycle set and clear of r3: set wins
    @(negedge clk);
    zero_in(); longopM = 1; regwriteM = 1; writeregM = 3; lo_done = 1; lo_reg = 3;
    @(negedge clk);
    zero_in();
    #1 chk("set_wins_r3", sb_busy, 32'd1 << 3);
    lo_done = 1; lo_reg = 20;
    @(negedge clk);
    zero_in();
    #1 chk("spurious_lo_done", sb_busy, 32'd1 << 3);
    lo_done = 1; lo_reg = 3;
    @(negedge clk);
    zero_in();
    #1 chk("clear_r3", sb_busy, 0);

    // r0 never busy
    longopM = 1; regwriteM = 1; writeregM = 0;
    @(negedge clk);
    zero_in();
    #1 chk("r0_never_busy", sb_busy, 0);

    // Exception in M blocks the commit; all flushes, no fetch stall
    longopM = 1; regwriteM = 1; writeregM = 14; flush_exceptionM = 1;
    #1 chk("flush_stallF", stallF, 0);
    chk("flush_all", {flushD, flushE, flushM, flushW}, 4'b1111);
    @(negedge clk);
    zero_in();
    #1 chk("flush_no_set", sb_busy, 0);

    // A stalled M stage does not commit
    longopM = 1; regwriteM = 1; writeregM = 15; d_stall = 1;
    @(negedge clk);
    zero_in();
    #1 chk("stallM_no_set", sb_busy, 0);

`ifdef HAZARD_PERF_EN
    do_reset();
    #1 chk("perf_reset", perf_stall_cnt, 0);
    @(negedge clk);
    i_stall = 1;
    repeat (5) @(negedge clk);
    i_stall = 0;
    #1 chk("perf_stall5", perf_stall_cnt, 5);
    chk("perf_sb0", perf_sb_cnt, 0);
    chk("perf_flush0", perf_flush_cnt, 0);
    flush_exceptionM = 1;
    repeat (2) @(negedge clk);
    flush_exceptionM = 0;
    #1 chk("perf_flush2", perf_flush_cnt, 2);
    chk("perf_sb_still0", perf_sb_cnt, 0);
`else
    do_reset();
    #1 chk("final_reset_outputs", obus, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
